// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Fetch PC register with a direct-mapped BTB and 2-bit counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic                  UpdE_i,
  input  logic [DATA_WIDTH-1:0] UpdPCE_i,
  input  logic                  UpdTakenE_i,
  input  logic [DATA_WIDTH-1:0] UpdTargetE_i,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] PCPlus4F_o,
  output logic                  PredTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  localparam logic [DATA_WIDTH-1:0] ALIGN = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] FOUR  = {{(DATA_WIDTH-3){1'b0}}, 3'b100};

  logic [DATA_WIDTH-1:0]         pc_q;
  logic [DATA_WIDTH-1:0]         next_pc;
  logic [BTB_ENTRIES-1:0]        btb_valid;
  logic [BTB_ENTRIES-1:0][1:0]   btb_ctr;
  logic [TAG_W-1:0]              btb_tag    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]         btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             unused_upd_lsb;

  assign PCF_o          = pc_q;
  assign f_idx          = pc_q[IDX_W+1:2];
  assign f_tag          = pc_q[DATA_WIDTH-1:IDX_W+2];
  assign f_hit          = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign u_idx          = UpdPCE_i[IDX_W+1:2];
  assign u_tag          = UpdPCE_i[DATA_WIDTH-1:IDX_W+2];
  assign u_hit          = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
  assign unused_upd_lsb = ^UpdPCE_i[1:0];

  assign PCPlus4F_o    = pc_q + FOUR;
  assign PredTakenF_o  = f_hit & btb_ctr[f_idx][1];
  assign PredTargetF_o = PredTakenF_o ? btb_target[f_idx] : PCPlus4F_o;

  // Execute redirect outranks a stall; stored targets are already aligned.
  always_comb begin
    next_pc = pc_q;
    if (PCSrcE_i)
      next_pc = PCTargetE_i & ALIGN;
    else if (en_i)
      next_pc = PredTargetF_o;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_q <= RESET_PC & ALIGN;
    else
      pc_q <= next_pc;
  end

  // Tags and targets need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
      btb_ctr   <= {BTB_ENTRIES{2'b01}};
    end else if (UpdE_i) begin
      if (u_hit) begin
        if (UpdTakenE_i) begin
          if (btb_ctr[u_idx] != 2'b11)
            btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'b01;
          btb_target[u_idx] <= UpdTargetE_i & ALIGN;
        end else if (btb_ctr[u_idx] != 2'b00) begin
          btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'b01;
        end
      end else if (UpdTakenE_i) begin
        btb_valid[u_idx]  <= 1'b1;
        btb_tag[u_idx]    <= u_tag;
        btb_target[u_idx] <= UpdTargetE_i & ALIGN;
        btb_ctr[u_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        PCSrcE_i;
  logic [31:0] PCTargetE_i;
  logic        UpdE_i;
  logic [31:0] UpdPCE_i;
  logic        UpdTakenE_i;
  logic [31:0] UpdTargetE_i;
  logic [31:0] PCF_o;
  logic [31:0] PCPlus4F_o;
  logic        PredTakenF_o;
  logic [31:0] PredTargetF_o;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.DATA_WIDTH(32), .BTB_ENTRIES(4), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .PCSrcE_i     (PCSrcE_i),
    .PCTargetE_i  (PCTargetE_i),
    .UpdE_i       (UpdE_i),
    .UpdPCE_i     (UpdPCE_i),
    .UpdTakenE_i  (UpdTakenE_i),
    .UpdTargetE_i (UpdTargetE_i),
    .PCF_o        (PCF_o),
    .PCPlus4F_o   (PCPlus4F_o),
    .PredTakenF_o (PredTakenF_o),
    .PredTargetF_o(PredTargetF_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    PCSrcE_i = 1'b1; PCTargetE_i = tgt;
    step();
    PCSrcE_i = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    UpdE_i = 1'b1; UpdPCE_i = pc; UpdTakenE_i = taken; UpdTargetE_i = tgt;
    step();
    UpdE_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; PCSrcE_i = 1'b0; PCTargetE_i = '0;
    UpdE_i = 1'b0; UpdPCE_i = '0; UpdTakenE_i = 1'b0; UpdTargetE_i = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_pc",      PCF_o,              32'h0);
    chk("reset_plus4",   PCPlus4F_o,         32'h4);
    chk("reset_pred",    {31'b0, PredTakenF_o}, 32'h0);
    chk("reset_ptgt",    PredTargetF_o,      32'h4);

    // Sequential fetch
    en_i = 1'b1;
    step(); chk("seq_4", PCF_o, 32'h4);
    step(); chk("seq_8", PCF_o, 32'h8);
    chk("seq_pred", {31'b0, PredTakenF_o}, 32'h0);

    // Stall, then redirect during stall
    en_i = 1'b0;
    step(); chk("stall_1", PCF_o, 32'h8);
    step(); chk("stall_2", PCF_o, 32'h8);
    redirect(32'h40); chk("redir_stall", PCF_o, 32'h40);
    en_i = 1'b1;
    step(); chk("after_redir", PCF_o, 32'h44);

    // Allocate 0x10 -> 0x80 while fetching
    upd(32'h10, 1'b1, 32'h80);
    chk("alloc_fetch", PCF_o, 32'h48);
    redirect(32'h10);
    chk("alloc_pc",   PCF_o, 32'h10);
    chk("alloc_pred", {31'b0, PredTakenF_o}, 32'h1);
    chk("alloc_ptgt", PredTargetF_o, 32'h80);
    step(); chk("pred_follow", PCF_o, 32'h80);

    // Counter walk at 0x10 while stalled
    redirect(32'h10);
    en_i = 1'b0;
    chk("ctr10_pred", {31'b0, PredTakenF_o}, 32'h1);
    upd(32'h10, 1'b0, 32'h0);
    chk("ctr01_pred", {31'b0, PredTakenF_o}, 32'h0);
    chk("ctr01_ptgt", PredTargetF_o, 32'h14);
    chk("ctr01_hold", PCF_o, 32'h10);
    upd(32'h10, 1'b0, 32'h0);
    chk("ctr00_pred", {31'b0, PredTakenF_o}, 32'h0);
    upd(32'h10, 1'b0, 32'h0);
    upd(32'h10, 1'b1, 32'h80);
    chk("ctr_sat0_pred", {31'b0, PredTakenF_o}, 32'h0);
    upd(32'h10, 1'b1, 32'h80);
    chk("ctr10b_pred", {31'b0, PredTakenF_o}, 32'h1);
    chk("ctr10b_ptgt", PredTargetF_o, 32'h80);
    upd(32'h10, 1'b1, 32'h93);
    chk("tgt_overwrite", PredTargetF_o, 32'h90);
    upd(32'h10, 1'b1, 32'h90);
    chk("ctr11_pred", {31'b0, PredTakenF_o}, 32'h1);
    upd(32'h10, 1'b0, 32'hAA0);
    chk("nt_keeps_tgt", PredTargetF_o, 32'h90);
    chk("ctr_sat3_a", {31'b0, PredTakenF_o}, 32'h1);
    upd(32'h10, 1'b0, 32'h0);
    chk("ctr_sat3_b", {31'b0, PredTakenF_o}, 32'h0);

    // Aliasing: 0x20 shares index 0 with 0x10; update concurrent with redirect
    UpdE_i = 1'b1; UpdPCE_i = 32'h20; UpdTakenE_i = 1'b1; UpdTargetE_i = 32'h100;
    PCSrcE_i = 1'b1; PCTargetE_i = 32'h20;
    step();
    UpdE_i = 1'b0; PCSrcE_i = 1'b0;
    chk("alias_pc",   PCF_o, 32'h20);
    chk("alias_pred", {31'b0, PredTakenF_o}, 32'h1);
    chk("alias_ptgt", PredTargetF_o, 32'h100);
    upd(32'h30, 1'b0, 32'h0);
    chk("nt_miss_pred", {31'b0, PredTakenF_o}, 32'h1);
    chk("nt_miss_ptgt", PredTargetF_o, 32'h100);
    redirect(32'h10);
    chk("alias_evict", {31'b0, PredTakenF_o}, 32'h0);
    chk("alias_evict_tgt", PredTargetF_o, 32'h14);
    redirect(32'h30);
    chk("nt_miss_noalloc", {31'b0, PredTakenF_o}, 32'h0);

    // Wrap and alignment
    redirect(32'hFFFF_FFFF);
    chk("wrap_pc",    PCF_o, 32'hFFFF_FFFC);
    chk("wrap_plus4", PCPlus4F_o, 32'h0);
    chk("wrap_ptgt",  PredTargetF_o, 32'h0);
    en_i = 1'b1;
    step(); chk("wrap_next", PCF_o, 32'h0);

    // Reset overrides redirect, enable and update
    rst = 1'b1; PCSrcE_i = 1'b1; PCTargetE_i = 32'h40;
    UpdE_i = 1'b1; UpdPCE_i = 32'h40; UpdTakenE_i = 1'b1; UpdTargetE_i = 32'h200;
    step();
    rst = 1'b0; PCSrcE_i = 1'b0; UpdE_i = 1'b0; en_i = 1'b0;
    chk("rst_ovr_pc", PCF_o, 32'h0);
    redirect(32'h20);
    chk("rst_clr_valid", {31'b0, PredTakenF_o}, 32'h0);
    redirect(32'h40);
    chk("rst_no_write", {31'b0, PredTakenF_o}, 32'h0);
    chk("rst_no_write_tgt", PredTargetF_o, 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
